input_layer_loader: RTL and testbench
=====================================

# input_layer_loader

Streaming front end of the digit classifier. Accepts pixel bytes one per cycle over a valid/ready handshake, packs each 62-byte frame into the flattened `inputLayer` vector consumed by the network datapath, and pulses `start` to the network controller. Ping-pong buffering lets the next frame load while the network computes on the current one.

## Interface
- `N_INPUTS`, 62: bytes per frame.
- `DATA_WIDTH`, 8: bits per byte.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-low reset (0 = reset).
- `inValid` in 1: `inData` valid this cycle.
- `inData` in 8: pixel byte; frame order index 0 first.
- `inLast` in 1: marks the final byte of a frame; qualified by `inValid`.
- `inReady` out 1: loader can accept a byte this cycle.
- `nnDone` in 1: one-cycle pulse from the network controller; the read bank is released.
- `errClr` in 1: clears `frameErr`.
- `inputLayer` out 8*62: read-bank contents. Byte i sits at bits [i*8+7 : i*8].
- `start` out 1: one-cycle pulse; a new frame is present on `inputLayer`.
- `busy` out 1: read bank is held by the network.
- `frameErr` out 1: sticky framing-error flag.

## Operation
- **Storage.** Two banks of 62×8 flops: a write bank and a read bank. `bankSel` selects which physical bank drives `inputLayer`; the other bank is the write bank.
- **State.**
  - `wrCount` (0..61)
  - `wrFull`
  - `rdBusy`
  - `bankSel`
  - `frameErr`
- **Accept.** A byte is accepted when `inValid && inReady`. It is written to write-bank byte `wrCount`.
- **`inReady`.** Equals `!wrFull`, registered.
- **Normal completion.** Accepted byte with `wrCount==61` and `inLast==1`: set `wrFull=1`, `wrCount` returns to 0.
- **Framing errors.** Both cases set `frameErr`, discard the partial frame (`wrCount` returns to 0, write-bank contents don't care), and issue no `start`:
  - Accepted byte with `inLast==1` and `wrCount!=61`.
  - Accepted byte with `wrCount==61` and `inLast==0`.
- **Swap.** At a clock edge where registered `wrFull==1 && rdBusy==0`:
  - toggle `bankSel`
  - `wrFull` becomes 0
  - `rdBusy` becomes 1
  - `start` becomes 1 for exactly one cycle
- **Release.** `nnDone==1` while `rdBusy==1` clears `rdBusy` at that edge. `nnDone` while `!rdBusy` is ignored.
- **`busy`** equals `rdBusy`.
- **`frameErr`** is cleared by `errClr`. Set has priority if both occur in the same cycle.
- **`inputLayer`** is held stable from a swap until the next swap.

## Timing
- **Reset values** (rising edge with `rst==0`):
  - `wrCount=0`, `wrFull=0`, `rdBusy=0`, `bankSel=0`
  - `start=0`, `frameErr=0`, `inReady=0`
  - both banks zero, so `inputLayer=0`
  - `inReady` goes to 1 at the first edge after `rst` returns high.
- **Mid-operation reset** discards any partial or held frame. No `start` is issued for it.
- **Latency.**
  - Last byte accepted at edge t with the read bank free: swap and `start` at edge t+1.
  - `inputLayer` is valid at edge t+1.
  - `inReady` returns to 1 at edge t+1.
- **Throughput.** Sustained rate is 62 bytes per 63 cycles when `nnDone` keeps pace.
- **Backpressure.** Write bank full and `rdBusy==1`:
  - `inReady` stays 0.
  - The swap occurs at the edge after the one where `nnDone` clears `rdBusy`.
- **Simultaneous events.** `nnDone` on the same edge that sets `wrFull`: `rdBusy` clears at that edge, and the swap happens at the next edge (never the same edge).
- **Start spacing.** `start` never asserts on consecutive cycles. A new `start` requires an intervening `nnDone`.

## Test plan
1. **Single frame.**
   - Stimulus: after reset, stream bytes 0x00..0x3D back-to-back with `inLast` on byte 61.
   - Required: `start` pulses 1 cycle after byte 61; `inputLayer[7:0]=0x00`, `inputLayer[495:488]=0x3D`; `busy=1`.
2. **Double buffering.**
   - Stimulus: stream frame B (all bytes 0xAA) while frame A is busy.
   - Required: `inReady` drops after B's last byte; `inputLayer` stays A; `nnDone` → swap at the next edge, `start` pulses, `inputLayer` becomes all 0xAA.
3. **Early `inLast`.**
   - Stimulus: `inLast` on byte 10.
   - Required: `frameErr=1`, no `start`; the next clean 62-byte frame loads correctly and starts; `errClr` clears `frameErr`.
4. **Missing `inLast`.**
   - Stimulus: 62 bytes with `inLast=0`.
   - Required: `frameErr=1`, no `start`, `wrCount` back to 0.
5. **Reset mid-frame.**
   - Stimulus: `rst=0` after 30 bytes.
   - Required: all outputs at reset values; `inputLayer=0`; the following full frame produces exactly one `start`.
6. **Stray `nnDone`.**
   - Stimulus: `nnDone` while `busy=0`.
   - Required: no state change.
   - Stimulus: `nnDone` coincident with the edge that sets `wrFull`.
   - Required: swap one edge later.

Source files
------------

// File: rtl/input_layer_loader.sv
// Ping-pong frame loader: packs a valid/ready byte stream into the flattened
// inputLayer vector and hands each complete frame to the network with a start pulse.
module input_layer_loader #(
   parameter int unsigned N_INPUTS   = 62,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           inValid,
   input  logic [DATA_WIDTH-1:0]          inData,
   input  logic                           inLast,
   output logic                           inReady,
   input  logic                           nnDone,
   input  logic                           errClr,
   output logic [N_INPUTS*DATA_WIDTH-1:0] inputLayer,
   output logic                           start,
   output logic                           busy,
   output logic                           frameErr
);

   localparam int unsigned CW = $clog2(N_INPUTS);
   localparam logic [CW-1:0] LAST_IDX = CW'(N_INPUTS - 1);

   logic [CW-1:0]                  wrCount_q, wrCount_d;
   logic                           wrFull_q, wrFull_d;
   logic                           rdBusy_q, rdBusy_d;
   logic                           bankSel_q, bankSel_d;
   logic                           frameErr_q, frameErr_d;
   logic                           inReady_q, inReady_d;
   logic                           start_q, start_d;
   logic [N_INPUTS*DATA_WIDTH-1:0] bank0_q, bank0_d;
   logic [N_INPUTS*DATA_WIDTH-1:0] bank1_q, bank1_d;

   logic accept;
   logic swap;
   logic errSet;

   assign accept = inValid & inReady_q;
   assign swap   = wrFull_q & ~rdBusy_q;

   always_comb begin
      wrCount_d = wrCount_q;
      wrFull_d  = wrFull_q;
      rdBusy_d  = rdBusy_q;
      bankSel_d = bankSel_q;
      start_d   = 1'b0;
      errSet    = 1'b0;
      bank0_d   = bank0_q;
      bank1_d   = bank1_q;

      if (accept) begin
         // The write bank is whichever physical bank is not driving inputLayer.
         if (bankSel_q) begin
            bank0_d[wrCount_q*DATA_WIDTH +: DATA_WIDTH] = inData;
         end else begin
            bank1_d[wrCount_q*DATA_WIDTH +: DATA_WIDTH] = inData;
         end

         if (inLast && (wrCount_q == LAST_IDX)) begin
            wrFull_d  = 1'b1;
            wrCount_d = '0;
         end else if (inLast || (wrCount_q == LAST_IDX)) begin
            errSet    = 1'b1;
            wrCount_d = '0;
         end else begin
            wrCount_d = wrCount_q + 1'b1;
         end
      end

      // Accept and swap never coincide: inReady_q is low whenever wrFull_q is high.
      if (swap) begin
         bankSel_d = ~bankSel_q;
         wrFull_d  = 1'b0;
         rdBusy_d  = 1'b1;
         start_d   = 1'b1;
      end else if (nnDone && rdBusy_q) begin
         rdBusy_d = 1'b0;
      end

      if (errSet) begin
         frameErr_d = 1'b1;
      end else if (errClr) begin
         frameErr_d = 1'b0;
      end else begin
         frameErr_d = frameErr_q;
      end

      inReady_d = ~wrFull_d;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wrCount_q  <= '0;
         wrFull_q   <= 1'b0;
         rdBusy_q   <= 1'b0;
         bankSel_q  <= 1'b0;
         frameErr_q <= 1'b0;
         inReady_q  <= 1'b0;
         start_q    <= 1'b0;
         bank0_q    <= '0;
         bank1_q    <= '0;
      end else begin
         wrCount_q  <= wrCount_d;
         wrFull_q   <= wrFull_d;
         rdBusy_q   <= rdBusy_d;
         bankSel_q  <= bankSel_d;
         frameErr_q <= frameErr_d;
         inReady_q  <= inReady_d;
         start_q    <= start_d;
         bank0_q    <= bank0_d;
         bank1_q    <= bank1_d;
      end
   end

   assign inReady    = inReady_q;
   assign start      = start_q;
   assign busy       = rdBusy_q;
   assign frameErr   = frameErr_q;
   assign inputLayer = bankSel_q ? bank1_q : bank0_q;

endmodule

// File: tb/tb_input_layer_loader.sv
// Directed self-checking bench for input_layer_loader: table of frame scenarios
// plus hand-written sequences for latency, backpressure, reset and nnDone corners.
module tb_input_layer_loader;

   localparam int unsigned N = 62;
   localparam int unsigned W = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             inValid;
   logic [W-1:0]     inData;
   logic             inLast;
   logic             inReady;
   logic             nnDone;
   logic             errClr;
   logic [N*W-1:0]   inputLayer;
   logic             start;
   logic             busy;
   logic             frameErr;

   int checks   = 0;
   int failures = 0;

   input_layer_loader #(.N_INPUTS(N), .DATA_WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .inValid    (inValid),
      .inData     (inData),
      .inLast     (inLast),
      .inReady    (inReady),
      .nnDone     (nnDone),
      .errClr     (errClr),
      .inputLayer (inputLayer),
      .start      (start),
      .busy       (busy),
      .frameErr   (frameErr)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      int          nbytes;
      int          last_pos;
      logic [7:0]  base;
      logic [7:0]  step;
      int          exp_starts;
      logic        exp_err;
      logic [7:0]  exp_b0;
      logic [7:0]  exp_b61;
      logic        clr;
   } vec_t;

   task automatic chk(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   function automatic logic [7:0] byte_at(input int i);
      return inputLayer[i*W +: W];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] d, input logic last, input logic nn);
      logic rdy;
      logic done;
      done    = 1'b0;
      inValid = 1'b1;
      inData  = d;
      inLast  = last;
      nnDone  = nn;
      for (int k = 0; k < 200 && !done; k++) begin
         rdy = inReady;
         tick();
         if (rdy) done = 1'b1;
      end
      inValid = 1'b0;
      inLast  = 1'b0;
      nnDone  = 1'b0;
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout: byte %0h not accepted within 200 cycles", d);
      end
   endtask

   task automatic send_frame(input int nbytes, input int last_pos, input logic [7:0] base,
                             input logic [7:0] step, input logic nn_on_last);
      for (int i = 0; i < nbytes; i++) begin
         send_byte(base + step * 8'(i), (i == last_pos), nn_on_last && (i == nbytes - 1));
      end
   endtask

   task automatic watch(input int n, output int s);
      s = 0;
      for (int k = 0; k < n; k++) begin
         tick();
         if (start) s++;
      end
   endtask

   task automatic pulse_nn();
      nnDone = 1'b1;
      tick();
      nnDone = 1'b0;
   endtask

   task automatic pulse_clr();
      errClr = 1'b1;
      tick();
      errClr = 1'b0;
   endtask

   vec_t vecs[6];
   int   s;
   logic [N*W-1:0] allAA;

   initial begin
      vecs[0] = '{11, 10, 8'h50, 8'h01, 0, 1'b1, 8'h00, 8'h00, 1'b0}; // early inLast
      vecs[1] = '{62, 61, 8'h10, 8'h03, 1, 1'b1, 8'h10, 8'hC7, 1'b1}; // clean, err still sticky
      vecs[2] = '{62, -1, 8'h33, 8'h00, 0, 1'b1, 8'h00, 8'h00, 1'b1}; // missing inLast
      vecs[3] = '{62, 61, 8'hFF, 8'hFF, 1, 1'b0, 8'hFF, 8'hC2, 1'b0}; // clean, descending
      vecs[4] = '{ 1,  0, 8'h99, 8'h00, 0, 1'b1, 8'h00, 8'h00, 1'b1}; // inLast on byte 0
      vecs[5] = '{62, 61, 8'h00, 8'h04, 1, 1'b0, 8'h00, 8'hF4, 1'b0}; // clean, step 4
      for (int i = 0; i < int'(N); i++) allAA[i*W +: W] = 8'hAA;

      rst = 1'b0; inValid = 1'b0; inData = '0; inLast = 1'b0; nnDone = 1'b0; errClr = 1'b0;
      tick(); tick(); tick();
      chk("rst_inReady", inReady, 0);
      chk("rst_start", start, 0);
      chk("rst_busy", busy, 0);
      chk("rst_frameErr", frameErr, 0);
      chk("rst_inputLayer", inputLayer, 0);
      rst = 1'b1;
      tick();
      chk("rst_release_inReady", inReady, 1);

      // Single frame 0x00..0x3D, latency of start and data
      send_frame(62, 61, 8'h00, 8'h01, 1'b0);
      chk("t1_start_early", start, 0);
      chk("t1_inReady_full", inReady, 0);
      chk("t1_busy_early", busy, 0);
      tick();
      chk("t1_start", start, 1);
      chk("t1_busy", busy, 1);
      chk("t1_inReady_back", inReady, 1);
      chk("t1_byte0", byte_at(0), 8'h00);
      chk("t1_byte30", byte_at(30), 8'h1E);
      chk("t1_byte61", byte_at(61), 8'h3D);
      tick();
      chk("t1_start_once", start, 0);

      // Double buffering: frame B loads while A is held
      send_frame(62, 61, 8'hAA, 8'h00, 1'b0);
      chk("t2_inReady_drop", inReady, 0);
      watch(3, s);
      chk("t2_no_start_held", s, 0);
      chk("t2_inReady_held", inReady, 0);
      chk("t2_A_byte0", byte_at(0), 8'h00);
      chk("t2_A_byte61", byte_at(61), 8'h3D);
      pulse_nn();
      chk("t2_busy_released", busy, 0);
      chk("t2_no_start_on_release", start, 0);
      tick();
      chk("t2_start", start, 1);
      chk("t2_busy", busy, 1);
      chk("t2_inputLayer_AA", inputLayer, allAA);
      chk("t2_inReady_back", inReady, 1);
      tick();
      chk("t2_start_once", start, 0);
      pulse_nn();
      chk("t2_busy_clear", busy, 0);

      // Framing scenario table
      for (int v = 0; v < 6; v++) begin
         send_frame(vecs[v].nbytes, vecs[v].last_pos, vecs[v].base, vecs[v].step, 1'b0);
         watch(4, s);
         chk($sformatf("v%0d_starts", v), s, vecs[v].exp_starts);
         chk($sformatf("v%0d_frameErr", v), frameErr, vecs[v].exp_err);
         if (vecs[v].exp_starts == 1) begin
            chk($sformatf("v%0d_busy", v), busy, 1);
            chk($sformatf("v%0d_byte0", v), byte_at(0), vecs[v].exp_b0);
            chk($sformatf("v%0d_byte61", v), byte_at(61), vecs[v].exp_b61);
            pulse_nn();
         end
         chk($sformatf("v%0d_busy_idle", v), busy, 0);
         if (vecs[v].clr) begin
            pulse_clr();
            chk($sformatf("v%0d_errClr", v), frameErr, 0);
         end
      end

      // Reset with a held frame, a sticky error and a partial frame in flight
      send_frame(62, 61, 8'h60, 8'h00, 1'b0);
      watch(2, s);
      chk("t5_held_start", s, 1);
      send_frame(3, 2, 8'h01, 8'h01, 1'b0);
      chk("t5_err_before_rst", frameErr, 1);
      send_frame(30, -1, 8'h05, 8'h01, 1'b0);
      rst = 1'b0;
      tick(); tick();
      chk("t5_rst_inReady", inReady, 0);
      chk("t5_rst_start", start, 0);
      chk("t5_rst_busy", busy, 0);
      chk("t5_rst_frameErr", frameErr, 0);
      chk("t5_rst_inputLayer", inputLayer, 0);
      rst = 1'b1;
      tick();
      chk("t5_rst_release_inReady", inReady, 1);
      send_frame(62, 61, 8'h20, 8'h01, 1'b0);
      watch(5, s);
      chk("t5_one_start", s, 1);
      chk("t5_byte0", byte_at(0), 8'h20);
      chk("t5_byte61", byte_at(61), 8'h5D);
      pulse_nn();

      // Stray nnDone while idle
      pulse_nn();
      chk("t6_stray_busy", busy, 0);
      chk("t6_stray_start", start, 0);
      chk("t6_stray_inReady", inReady, 1);
      chk("t6_stray_byte0", byte_at(0), 8'h20);
      watch(3, s);
      chk("t6_stray_no_start", s, 0);

      // nnDone on the same edge that fills the write bank
      send_frame(62, 61, 8'h40, 8'h00, 1'b0);
      watch(3, s);
      chk("t6_X_start", s, 1);
      chk("t6_X_busy", busy, 1);
      send_frame(62, 61, 8'h77, 8'h00, 1'b1);
      chk("t6_coinc_busy", busy, 0);
      chk("t6_coinc_no_start", start, 0);
      chk("t6_coinc_inReady", inReady, 0);
      chk("t6_coinc_still_X", byte_at(0), 8'h40);
      tick();
      chk("t6_coinc_start", start, 1);
      chk("t6_coinc_busy_set", busy, 1);
      chk("t6_coinc_byte0", byte_at(0), 8'h77);
      chk("t6_coinc_byte61", byte_at(61), 8'h77);
      tick();
      chk("t6_coinc_start_once", start, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
